// File: rtl/adder_share_arbiter.sv
// ============================================================================
//  Module   : adder_share_arbiter (with helper adder_nbit_top)
//  Purpose  : Round-robin sharing of one N-bit adder between two requesters,
//             with registered sum and active-low seven-segment display.
//             Optional display hold state enabled by macro ADDER_SHARE_HOLD_EN.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module adder_nbit_top #(
  parameter int N = 3
) (
  input  logic [N-1:0] i_a,
  input  logic [N-1:0] i_b,
  output logic [N:0]   o_sum
);
  logic [N:0] w_carry;

  assign w_carry[0] = 1'b0;

  for (genvar i = 0; i < N; i++) begin : g_bit
    assign o_sum[i]     = i_a[i] ^ i_b[i] ^ w_carry[i];
    assign w_carry[i+1] = (i_a[i] & i_b[i]) | (w_carry[i] & (i_a[i] ^ i_b[i]));
  end

  assign o_sum[N] = w_carry[N];
endmodule

module adder_share_arbiter #(
  parameter int N           = 3,
  parameter int HOLD_CYCLES = 8
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic [1:0]   i_req,
  input  logic [N-1:0] i_a0,
  input  logic [N-1:0] i_b0,
  input  logic [N-1:0] i_a1,
  input  logic [N-1:0] i_b1,
  output logic [1:0]   o_gnt,
  output logic [1:0]   o_ack,
  output logic         o_busy,
  output logic         o_owner,
  output logic [N:0]   o_sum,
  output logic [6:0]   o_HEX
);
  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_GRANT   = 2'd1,
    S_COMPUTE = 2'd2,
    S_HOLD    = 2'd3
  } state_t;

  state_t       state_q, state_d;
  logic [1:0]   gnt_q, gnt_d;
  logic [1:0]   ack_q, ack_d;
  logic         busy_q, busy_d;
  logic         owner_q, owner_d;
  logic [N:0]   sum_q, sum_d;
  logic [6:0]   hex_q, hex_d;
  logic         last_q, last_d;
  logic         win_q, win_d;
  logic [N-1:0] a_q, a_d;
  logic [N-1:0] b_q, b_d;

`ifdef ADDER_SHARE_HOLD_EN
  localparam int HOLD_CNT_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  logic [HOLD_CNT_W-1:0] hold_cnt_q, hold_cnt_d;
`endif

  logic [N:0] w_sum;
  logic [3:0] w_nib;
  logic [6:0] w_hex;
  logic       w_win;

  adder_nbit_top #(.N(N)) u_adder (
    .i_a   (a_q),
    .i_b   (b_q),
    .o_sum (w_sum)
  );

  if (N >= 3) begin : g_nib_direct
    assign w_nib = w_sum[3:0];
  end else begin : g_nib_pad
    assign w_nib = {{(3-N){1'b0}}, w_sum};
  end

  always_comb begin
    w_hex = 7'b1000000;
    case (w_nib)
      4'h0: w_hex = 7'b1000000;
      4'h1: w_hex = 7'b1111001;
      4'h2: w_hex = 7'b0100100;
      4'h3: w_hex = 7'b0110000;
      4'h4: w_hex = 7'b0011001;
      4'h5: w_hex = 7'b0010010;
      4'h6: w_hex = 7'b0000010;
      4'h7: w_hex = 7'b1111000;
      4'h8: w_hex = 7'b0000000;
      4'h9: w_hex = 7'b0010000;
      4'hA: w_hex = 7'b0001000;
      4'hB: w_hex = 7'b0000011;
      4'hC: w_hex = 7'b1000110;
      4'hD: w_hex = 7'b0100001;
      4'hE: w_hex = 7'b0000110;
      default: w_hex = 7'b0001110;
    endcase
  end

  // On a tie the requester not served last wins; a lone request always wins.
  assign w_win = (i_req == 2'b11) ? ~last_q : i_req[1];

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    ack_d   = 2'b00;
    owner_d = owner_q;
    sum_d   = sum_q;
    hex_d   = hex_q;
    last_d  = last_q;
    win_d   = win_q;
    a_d     = a_q;
    b_d     = b_q;
`ifdef ADDER_SHARE_HOLD_EN
    hold_cnt_d = hold_cnt_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (|i_req) begin
          state_d = S_GRANT;
          gnt_d   = w_win ? 2'b10 : 2'b01;
          win_d   = w_win;
          a_d     = w_win ? i_a1 : i_a0;
          b_d     = w_win ? i_b1 : i_b0;
        end
      end
      // Operands are already frozen, so the result lands as COMPUTE begins.
      S_GRANT: begin
        state_d = S_COMPUTE;
        gnt_d   = 2'b00;
        ack_d   = win_q ? 2'b10 : 2'b01;
        sum_d   = w_sum;
        hex_d   = w_hex;
        owner_d = win_q;
        last_d  = win_q;
      end
      S_COMPUTE: begin
`ifdef ADDER_SHARE_HOLD_EN
        state_d    = S_HOLD;
        hold_cnt_d = '0;
`else
        state_d = S_IDLE;
`endif
      end
      S_HOLD: begin
`ifdef ADDER_SHARE_HOLD_EN
        if (hold_cnt_q == HOLD_CNT_W'(HOLD_CYCLES - 1)) begin
          state_d = S_IDLE;
        end else begin
          hold_cnt_d = hold_cnt_q + HOLD_CNT_W'(1);
        end
`else
        state_d = S_IDLE;
`endif
      end
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= S_IDLE;
      gnt_q   <= 2'b00;
      ack_q   <= 2'b00;
      busy_q  <= 1'b0;
      owner_q <= 1'b0;
      sum_q   <= '0;
      hex_q   <= 7'b1000000;
      last_q  <= 1'b1;
      win_q   <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
`ifdef ADDER_SHARE_HOLD_EN
      hold_cnt_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      ack_q   <= ack_d;
      busy_q  <= busy_d;
      owner_q <= owner_d;
      sum_q   <= sum_d;
      hex_q   <= hex_d;
      last_q  <= last_d;
      win_q   <= win_d;
      a_q     <= a_d;
      b_q     <= b_d;
`ifdef ADDER_SHARE_HOLD_EN
      hold_cnt_q <= hold_cnt_d;
`endif
    end
  end

  assign o_gnt   = gnt_q;
  assign o_ack   = ack_q;
  assign o_busy  = busy_q;
  assign o_owner = owner_q;
  assign o_sum   = sum_q;
  assign o_HEX   = hex_q;
endmodule

`default_nettype wire
